i2c_txn_arbiter: RTL and testbench

//  Shares one byte-level I2C master (exec/done/ack handshake, 16-bit word address) between NUM_REQ clients.

---
 rtl/i2c_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/i2c_txn_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C transaction arbiter: FSM state encoding and response status codes.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam logic RSP_OK   = 1'b0;
  localparam logic RSP_FAIL = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit searching upward from ptr+1, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      idx,
  output logic               valid
);

  logic          found;
  logic [PW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  assign grant = found ? (NUM_REQ'(1) << idx) : '0;
  assign valid = found;

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sharing of one byte-level I2C master among NUM_REQ clients, with post-write idle gap.
// Define I2C_TIMEOUT_EN to add a WAIT_DONE watchdog that fails the transaction after TIMEOUT_CYCLES.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 16,
  parameter int GAP_CYCLES     = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_rh_wl,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]  req_data_w,
  output logic [NUM_REQ-1:0]    req_accept,
  output logic [NUM_REQ-1:0]    rsp_done,
  output logic [7:0]            rsp_data_r,
  output logic                  rsp_ack,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  i2c_exec,
  output logic                  i2c_rh_wl,
  output logic [ADDR_W-1:0]     i2c_addr,
  output logic [7:0]            i2c_data_w,
  input  logic [7:0]            i2c_data_r,
  input  logic                  i2c_done,
  input  logic                  i2c_ack
);

  localparam int PW    = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   req_accept_q, req_accept_d;
  logic [NUM_REQ-1:0]   rsp_done_q, rsp_done_d;
  logic [7:0]           rsp_data_r_q, rsp_data_r_d;
  logic                 rsp_ack_q, rsp_ack_d;
  logic                 busy_q, busy_d;
  logic                 i2c_exec_q, i2c_exec_d;
  logic                 i2c_rh_wl_q, i2c_rh_wl_d;
  logic [ADDR_W-1:0]    i2c_addr_q, i2c_addr_d;
  logic [7:0]           i2c_data_w_q, i2c_data_w_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [PW-1:0]        arb_idx;
  logic                 arb_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

`ifdef I2C_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    req_accept_d = '0;
    rsp_done_d   = '0;
    rsp_data_r_d = rsp_data_r_q;
    rsp_ack_d    = rsp_ack_q;
    busy_d       = busy_q;
    i2c_exec_d   = 1'b0;
    i2c_rh_wl_d  = i2c_rh_wl_q;
    i2c_addr_d   = i2c_addr_q;
    i2c_data_w_d = i2c_data_w_q;
    gap_cnt_d    = gap_cnt_q;
`ifdef I2C_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          req_accept_d = arb_grant;
          gnt_d        = arb_grant;
          ptr_d        = arb_idx;
          i2c_rh_wl_d  = req_rh_wl[arb_idx];
          i2c_addr_d   = req_addr[arb_idx*ADDR_W +: ADDR_W];
          i2c_data_w_d = req_data_w[arb_idx*8 +: 8];
          busy_d       = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        i2c_exec_d = 1'b1;
        gap_cnt_d  = '0;
`ifdef I2C_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        state_d    = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done in the watchdog's final cycle still reports the master's real result.
        if (i2c_done) begin
          rsp_done_d   = gnt_q;
          rsp_data_r_d = i2c_data_r;
          rsp_ack_d    = i2c_ack;
          if (!i2c_rh_wl_q && GAP_CYCLES > 0) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
`ifdef I2C_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          rsp_done_d    = gnt_q;
          rsp_data_r_d  = 8'h00;
          rsp_ack_d     = RSP_FAIL;
          state_d       = IDLE;
          busy_d        = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to the last client so client 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= PW'(NUM_REQ - 1);
      gnt_q        <= '0;
      req_accept_q <= '0;
      rsp_done_q   <= '0;
      rsp_data_r_q <= '0;
      rsp_ack_q    <= RSP_OK;
      busy_q       <= 1'b0;
      i2c_exec_q   <= 1'b0;
      i2c_rh_wl_q  <= 1'b0;
      i2c_addr_q   <= '0;
      i2c_data_w_q <= '0;
      gap_cnt_q    <= '0;
`ifdef I2C_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      req_accept_q <= req_accept_d;
      rsp_done_q   <= rsp_done_d;
      rsp_data_r_q <= rsp_data_r_d;
      rsp_ack_q    <= rsp_ack_d;
      busy_q       <= busy_d;
      i2c_exec_q   <= i2c_exec_d;
      i2c_rh_wl_q  <= i2c_rh_wl_d;
      i2c_addr_q   <= i2c_addr_d;
      i2c_data_w_q <= i2c_data_w_d;
      gap_cnt_q    <= gap_cnt_d;
`ifdef I2C_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign req_accept = req_accept_q;
  assign rsp_done   = rsp_done_q;
  assign rsp_data_r = rsp_data_r_q;
  assign rsp_ack    = rsp_ack_q;
  assign busy       = busy_q;
  assign i2c_exec   = i2c_exec_q;
  assign i2c_rh_wl  = i2c_rh_wl_q;
  assign i2c_addr   = i2c_addr_q;
  assign i2c_data_w = i2c_data_w_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter (4 clients, 8-cycle write gap, 64-cycle watchdog).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_i2c_txn_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_rh_wl;
  logic [63:0] req_addr;
  logic [31:0] req_data_w;
  logic [3:0]  req_accept;
  logic [3:0]  rsp_done;
  logic [7:0]  rsp_data_r;
  logic        rsp_ack;
  logic        busy;
  logic        timeout_err;
  logic        i2c_exec;
  logic        i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic [7:0]  i2c_data_r;
  logic        i2c_done;
  logic        i2c_ack;

  int errors = 0;
  int checks = 0;

  i2c_txn_arbiter #(
    .NUM_REQ        (4),
    .ADDR_W         (16),
    .GAP_CYCLES     (8),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_rh_wl   (req_rh_wl),
    .req_addr    (req_addr),
    .req_data_w  (req_data_w),
    .req_accept  (req_accept),
    .rsp_done    (rsp_done),
    .rsp_data_r  (rsp_data_r),
    .rsp_ack     (rsp_ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .i2c_exec    (i2c_exec),
    .i2c_rh_wl   (i2c_rh_wl),
    .i2c_addr    (i2c_addr),
    .i2c_data_w  (i2c_data_w),
    .i2c_data_r  (i2c_data_r),
    .i2c_done    (i2c_done),
    .i2c_ack     (i2c_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic cycle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic rh, input logic [15:0] a, input logic [7:0] d);
    req_rh_wl[k]        = rh;
    req_addr[k*16 +: 16] = a;
    req_data_w[k*8 +: 8] = d;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    i2c_done  = 1'b0;
    i2c_ack   = 1'b0;
    cycle(2);
    rst_n = 1'b1;
    cycle(1);
  endtask

  task automatic test_reset;
    cycle(1);
    checks++;
    if ({req_accept, rsp_done, busy, i2c_exec, timeout_err, rsp_ack} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b want 000000000000", {req_accept, rsp_done, busy, i2c_exec, timeout_err, rsp_ack});
    end
    checks++;
    if ({i2c_addr, i2c_data_w, rsp_data_r, i2c_rh_wl} !== 33'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h want 0", {i2c_addr, i2c_data_w, rsp_data_r, i2c_rh_wl});
    end
    rst_n = 1'b1;
    cycle(2);
    checks++;
    if (busy !== 1'b0 || req_accept !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%b accept=%b want 0 0000", busy, req_accept);
    end
  endtask

  task automatic test_write;
    set_req(1, 1'b0, 16'h0012, 8'hA5);
    req_valid = 4'b0010;
    cycle(1);
    checks++;
    if (req_accept !== 4'b0010 || busy !== 1'b1 || i2c_exec !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_accept: accept=%b busy=%b exec=%b want 0010 1 0", req_accept, busy, i2c_exec);
    end
    req_valid = 4'b0000;
    cycle(1);
    checks++;
    if (i2c_exec !== 1'b1 || i2c_addr !== 16'h0012 || i2c_data_w !== 8'hA5 || i2c_rh_wl !== 1'b0 || req_accept !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL wr_exec: exec=%b addr=%h data=%h rh_wl=%b acc=%b want 1 0012 a5 0 0000",
               i2c_exec, i2c_addr, i2c_data_w, i2c_rh_wl, req_accept);
    end
    cycle(1);
    checks++;
    if (i2c_exec !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_exec_pulse: exec=%b want 0", i2c_exec);
    end
    i2c_ack  = 1'b0;
    i2c_done = 1'b1;
    cycle(1);
    i2c_done = 1'b0;
    checks++;
    if (rsp_done !== 4'b0010 || rsp_ack !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wr_rsp: done=%b ack=%b busy=%b want 0010 0 1", rsp_done, rsp_ack, busy);
    end
    set_req(0, 1'b1, 16'h0040, 8'h00);
    req_valid = 4'b0001;
    cycle(1);
    checks++;
    if (rsp_done !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL wr_rsp_pulse: done=%b want 0000", rsp_done);
    end
    cycle(6);
    checks++;
    if (busy !== 1'b1 || req_accept !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL gap_hold: busy=%b accept=%b want 1 0000", busy, req_accept);
    end
    cycle(1);
    checks++;
    if (busy !== 1'b0 || req_accept !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL gap_end: busy=%b accept=%b want 0 0000", busy, req_accept);
    end
    cycle(1);
    checks++;
    if (req_accept !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL after_gap_grant: accept=%b want 0001", req_accept);
    end
    req_valid = 4'b0000;
    cycle(1);
    i2c_data_r = 8'h77;
    i2c_done   = 1'b1;
    cycle(1);
    i2c_done = 1'b0;
    checks++;
    if (rsp_done !== 4'b0001 || rsp_data_r !== 8'h77 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_gap_rsp: done=%b data=%h busy=%b want 0001 77 0", rsp_done, rsp_data_r, busy);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_oh;
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 16'h0100 + 16'(k), 8'h00);
    req_valid = 4'b1111;
    cycle(1);
    for (int j = 0; j < 5; j++) begin
      exp_oh = 4'b0001 << (j % 4);
      checks++;
      if (req_accept !== exp_oh) begin
        errors++;
        $display("[TB] FAIL rr_accept%0d: got %b want %b", j, req_accept, exp_oh);
      end
      if (j == 4) req_valid = 4'b0000;
      cycle(1);
      checks++;
      if (i2c_exec !== 1'b1 || i2c_addr !== 16'h0100 + 16'(j % 4)) begin
        errors++;
        $display("[TB] FAIL rr_exec%0d: exec=%b addr=%h want 1 %h", j, i2c_exec, i2c_addr, 16'h0100 + 16'(j % 4));
      end
      i2c_data_r = 8'h30 + 8'(j);
      i2c_done   = 1'b1;
      cycle(1);
      i2c_done = 1'b0;
      checks++;
      if (rsp_done !== exp_oh || rsp_data_r !== 8'h30 + 8'(j)) begin
        errors++;
        $display("[TB] FAIL rr_rsp%0d: done=%b data=%h want %b %h", j, rsp_done, rsp_data_r, exp_oh, 8'h30 + 8'(j));
      end
      cycle(1);
    end
  endtask

  task automatic test_read;
    set_req(2, 1'b1, 16'h00FF, 8'h00);
    req_valid = 4'b0100;
    cycle(1);
    checks++;
    if (req_accept !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL rd_accept: got %b want 0100", req_accept);
    end
    req_valid = 4'b0000;
    cycle(1);
    checks++;
    if (i2c_exec !== 1'b1 || i2c_rh_wl !== 1'b1 || i2c_addr !== 16'h00FF) begin
      errors++;
      $display("[TB] FAIL rd_exec: exec=%b rh_wl=%b addr=%h want 1 1 00ff", i2c_exec, i2c_rh_wl, i2c_addr);
    end
    i2c_data_r = 8'h5A;
    i2c_ack    = 1'b0;
    i2c_done   = 1'b1;
    cycle(1);
    i2c_done = 1'b0;
    checks++;
    if (rsp_done !== 4'b0100 || rsp_data_r !== 8'h5A || rsp_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rd_rsp: done=%b data=%h ack=%b busy=%b want 0100 5a 0 0", rsp_done, rsp_data_r, rsp_ack, busy);
    end
    i2c_data_r = 8'hEE;
    i2c_ack    = 1'b1;
    cycle(1);
    i2c_done = 1'b1;
    cycle(1);
    i2c_done = 1'b0;
    cycle(1);
    checks++;
    if (rsp_done !== 4'b0000 || rsp_data_r !== 8'h5A || rsp_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_done: done=%b data=%h ack=%b busy=%b want 0000 5a 0 0", rsp_done, rsp_data_r, rsp_ack, busy);
    end
    i2c_ack = 1'b0;
  endtask

  task automatic test_nack;
    set_req(0, 1'b0, 16'h0055, 8'h12);
    set_req(3, 1'b1, 16'h0333, 8'h00);
    req_valid = 4'b1001;
    cycle(1);
    checks++;
    if (req_accept !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL nack_accept: got %b want 0001", req_accept);
    end
    req_valid = 4'b1000;
    cycle(1);
    i2c_ack  = 1'b1;
    i2c_done = 1'b1;
    cycle(1);
    i2c_done = 1'b0;
    i2c_ack  = 1'b0;
    checks++;
    if (rsp_done !== 4'b0001 || rsp_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nack_rsp: done=%b ack=%b want 0001 1", rsp_done, rsp_ack);
    end
    cycle(8);
    checks++;
    if (busy !== 1'b0 || req_accept !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL nack_gap: busy=%b accept=%b want 0 0000", busy, req_accept);
    end
    cycle(1);
    checks++;
    if (req_accept !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL nack_next: accept=%b want 1000", req_accept);
    end
    req_valid = 4'b0000;
    cycle(1);
    checks++;
    if (i2c_exec !== 1'b1 || i2c_addr !== 16'h0333 || i2c_rh_wl !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nack_next_exec: exec=%b addr=%h rh_wl=%b want 1 0333 1", i2c_exec, i2c_addr, i2c_rh_wl);
    end
    i2c_data_r = 8'h11;
    i2c_done   = 1'b1;
    cycle(1);
    i2c_done = 1'b0;
    checks++;
    if (rsp_done !== 4'b1000 || rsp_ack !== 1'b0 || rsp_data_r !== 8'h11) begin
      errors++;
      $display("[TB] FAIL nack_next_rsp: done=%b ack=%b data=%h want 1000 0 11", rsp_done, rsp_ack, rsp_data_r);
    end
  endtask

  task automatic test_reset_mid;
    set_req(1, 1'b0, 16'h0123, 8'h3C);
    req_valid = 4'b0010;
    cycle(1);
    checks++;
    if (req_accept !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL mid_accept: got %b want 0010", req_accept);
    end
    req_valid = 4'b0000;
    cycle(2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, i2c_exec, req_accept, rsp_done, rsp_ack, i2c_rh_wl} !== 12'h000 ||
        {i2c_addr, i2c_data_w, rsp_data_r} !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_clear: busy=%b addr=%h data_w=%h data_r=%h acc=%b done=%b",
               busy, i2c_addr, i2c_data_w, rsp_data_r, req_accept, rsp_done);
    end
    i2c_done = 1'b1;
    cycle(1);
    rst_n = 1'b1;
    set_req(0, 1'b1, 16'h0A00, 8'h00);
    set_req(3, 1'b1, 16'h0A03, 8'h00);
    req_valid = 4'b1001;
    cycle(1);
    checks++;
    if (req_accept !== 4'b0001 || rsp_done !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL mid_regrant: accept=%b done=%b want 0001 0000", req_accept, rsp_done);
    end
    i2c_done  = 1'b0;
    req_valid = 4'b0000;
    cycle(2);
  endtask

  task automatic test_timeout;
    set_req(1, 1'b1, 16'h0200, 8'h00);
    req_valid = 4'b0010;
    cycle(1);
    req_valid = 4'b0000;
    cycle(1);
    i2c_data_r = 8'hC3;
    i2c_done   = 1'b1;
    cycle(1);
    i2c_done = 1'b0;
    checks++;
    if (rsp_done !== 4'b0010 || rsp_data_r !== 8'hC3) begin
      errors++;
      $display("[TB] FAIL to_pre_rsp: done=%b data=%h want 0010 c3", rsp_done, rsp_data_r);
    end
    set_req(2, 1'b0, 16'h0300, 8'h99);
    req_valid = 4'b0100;
    cycle(1);
    req_valid = 4'b0000;
    cycle(1);
    checks++;
    if (i2c_exec !== 1'b1 || i2c_addr !== 16'h0300) begin
      errors++;
      $display("[TB] FAIL to_exec: exec=%b addr=%h want 1 0300", i2c_exec, i2c_addr);
    end
    cycle(63);
    checks++;
    if (timeout_err !== 1'b0 || rsp_done !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_before: terr=%b done=%b busy=%b want 0 0000 1", timeout_err, rsp_done, busy);
    end
    cycle(1);
`ifdef I2C_TIMEOUT_EN
    checks++;
    if (timeout_err !== 1'b1 || rsp_done !== 4'b0100 || rsp_ack !== 1'b1 || rsp_data_r !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL to_expire: terr=%b done=%b ack=%b data=%h busy=%b want 1 0100 1 00 0",
               timeout_err, rsp_done, rsp_ack, rsp_data_r, busy);
    end
    cycle(1);
    checks++;
    if (timeout_err !== 1'b0 || rsp_done !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL to_pulse: terr=%b done=%b want 0 0000", timeout_err, rsp_done);
    end
`else
    checks++;
    if (busy !== 1'b1 || rsp_done !== 4'b0000 || timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_to_wait: busy=%b done=%b terr=%b want 1 0000 0", busy, rsp_done, timeout_err);
    end
    i2c_ack  = 1'b0;
    i2c_done = 1'b1;
    cycle(1);
    i2c_done = 1'b0;
    checks++;
    if (rsp_done !== 4'b0100 || rsp_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_to_late_done: done=%b ack=%b want 0100 0", rsp_done, rsp_ack);
    end
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_rh_wl  = '0;
    req_addr   = '0;
    req_data_w = '0;
    i2c_data_r = '0;
    i2c_done   = 1'b0;
    i2c_ack    = 1'b0;
    test_reset;
    test_write;
    do_reset;
    test_round_robin;
    do_reset;
    test_read;
    do_reset;
    test_nack;
    test_reset_mid;
    do_reset;
    test_timeout;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
